// File: rtl/data_memory_block_pkg.sv
// -----------------------------------------------------------------------------
// data_memory_block_pkg
// Shared constants and types for the memory-access (DM) stage of the 8-bit
// pipelined processor.
//   DATA_W : data word width (ALU result, store data, stage result)
//   ADDR_W : data memory address width; depth is 2**ADDR_W words
//   data_t : one data word
// -----------------------------------------------------------------------------
package data_memory_block_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [DATA_W-1:0] data_t;

endpackage : data_memory_block_pkg

// File: rtl/data_memory_block_dm_ram.sv
// -----------------------------------------------------------------------------
// data_memory_block_dm_ram
// Single-port 2**ADDR_W x DATA_W data memory.
// Synchronous write, synchronous clear of every word on reset, and a
// combinational read that returns zero while the port is disabled.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset, clears all words
//   en_i     : access enable
//   we_i     : 1 = write, 0 = read (only meaningful when en_i = 1)
//   addr_i   : word address
//   wdata_i  : write data
//   rdata_o  : combinational read data (old contents during a write)
// -----------------------------------------------------------------------------
module data_memory_block_dm_ram
    import data_memory_block_pkg::*;
#(
    parameter int RAM_DATA_W = DATA_W,
    parameter int RAM_ADDR_W = ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [RAM_ADDR_W-1:0] addr_i,
    input  logic [RAM_DATA_W-1:0] wdata_i,
    output logic [RAM_DATA_W-1:0] rdata_o
);

    localparam int RAM_DEPTH = 1 << RAM_ADDR_W;

    logic [RAM_DATA_W-1:0] mem_q [RAM_DEPTH];

    // Reset clears the whole array and beats any write in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RAM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read is taken from the array before the edge, so a read-during-write
    // to the same address sees the old word.
    assign rdata_o = en_i ? mem_q[addr_i] : '0;

endmodule : data_memory_block_dm_ram

// File: rtl/data_memory_block.sv
// -----------------------------------------------------------------------------
// data_memory_block
// Memory-access (DM) stage. The EX-stage ALU result addresses the data memory
// and DM_data is the store data. The registered stage result is either the
// loaded word or the pass-through ALU result, and feeds write-back.
// There is no handshake: every cycle is an independent transaction and
// ans_dm reflects the inputs of the previous rising edge.
// Ports:
//   clk            : rising-edge clock
//   reset          : synchronous active-low reset (0 = reset)
//   ans_ex         : ALU result; low ADDR_W bits are the memory address
//   DM_data        : store data
//   mem_rw_ex      : 1 = store, 0 = load
//   mem_en_ex      : memory access enable
//   mem_mux_sel_dm : 1 = result is memory read data, 0 = result is ans_ex
//   ans_dm         : registered stage result
// -----------------------------------------------------------------------------
module data_memory_block
    import data_memory_block_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] ans_ex,
    input  logic [DATA_W-1:0] DM_data,
    input  logic              mem_rw_ex,
    input  logic              mem_en_ex,
    input  logic              mem_mux_sel_dm,
    output logic [DATA_W-1:0] ans_dm
);

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] ans_dm_d;
    logic [DATA_W-1:0] ans_dm_q;

    // Only the low ADDR_W bits of the ALU result select a word.
    assign addr = ans_ex[ADDR_W-1:0];

    data_memory_block_dm_ram #(
        .RAM_DATA_W (DATA_W),
        .RAM_ADDR_W (ADDR_W)
    ) u_dm_ram (
        .clk     (clk),
        .rst_n   (reset),
        .en_i    (mem_en_ex),
        .we_i    (mem_rw_ex),
        .addr_i  (addr),
        .wdata_i (DM_data),
        .rdata_o (rd_data)
    );

    always_comb begin
        ans_dm_d = ans_ex;
        if (mem_mux_sel_dm) begin
            ans_dm_d = rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ans_dm_q <= '0;
        end else begin
            ans_dm_q <= ans_dm_d;
        end
    end

    assign ans_dm = ans_dm_q;

endmodule : data_memory_block

// File: tb/tb_data_memory_block.sv
// -----------------------------------------------------------------------------
// tb_data_memory_block
// Self-checking bench for the DM stage: each cycle's expected ans_dm is
// queued when the inputs are driven and checked one edge later.
// -----------------------------------------------------------------------------
module tb_data_memory_block;
    import data_memory_block_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        clk;
    logic        reset;
    logic [7:0]  ans_ex;
    logic [7:0]  DM_data;
    logic        mem_rw_ex;
    logic        mem_en_ex;
    logic        mem_mux_sel_dm;
    logic [7:0]  ans_dm;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    data_memory_block dut (
        .clk            (clk),
        .reset          (reset),
        .ans_ex         (ans_ex),
        .DM_data        (DM_data),
        .mem_rw_ex      (mem_rw_ex),
        .mem_en_ex      (mem_en_ex),
        .mem_mux_sel_dm (mem_mux_sel_dm),
        .ans_dm         (ans_dm)
    );

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    data_t      model_mem [DEPTH];
    int         n_compared;
    int         n_mismatched;

    // ---------------- driver ----------------
    // Applies one cycle of inputs away from the active edge, queues the
    // expected result, and returns #1 after the edge that registers it.
    // The reference memory tracks the writes and clears the bench makes.
    task automatic step(input logic rst, input logic en, input logic rw,
                        input logic sel, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] e);
        @(negedge clk);
        reset          = rst;
        mem_en_ex      = en;
        mem_rw_ex      = rw;
        mem_mux_sel_dm = sel;
        ans_ex         = a;
        DM_data        = d;
        exp_q.push_back(e);
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        end else if (en && rw) begin
            model_mem[a] = d;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] e;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 8'h03, 8'hFF, 8'h00);
            e = exp_q.pop_front();
            n_compared++;
            if (ans_dm !== e) begin
                n_mismatched++;
                $display("FAIL reset[%0d]: ans_dm=%h expected=%h", i, ans_dm, e);
            end
        end
    endtask

    task automatic test_pass_through();
        logic [7:0] e;
        logic [7:0] a_tab [4] = '{8'h03, 8'h5A, 8'h10, 8'h10};
        logic [7:0] e_tab [4] = '{8'h03, 8'h5A, 8'h10, 8'h3C};
        // 0x03, 0x5A pass through; store 0x3C at 0x10 with sel=0 (result is
        // still ans_ex), then load it back to prove the write happened.
        step(1'b1, 1'b0, 1'b0, 1'b0, a_tab[0], 8'h00, e_tab[0]);
        e = exp_q.pop_front(); n_compared++;
        if (ans_dm !== e) begin n_mismatched++; $display("FAIL pass_03: ans_dm=%h expected=%h", ans_dm, e); end
        step(1'b1, 1'b0, 1'b0, 1'b0, a_tab[1], 8'h00, e_tab[1]);
        e = exp_q.pop_front(); n_compared++;
        if (ans_dm !== e) begin n_mismatched++; $display("FAIL pass_5a: ans_dm=%h expected=%h", ans_dm, e); end
        step(1'b1, 1'b1, 1'b1, 1'b0, a_tab[2], 8'h3C, e_tab[2]);
        e = exp_q.pop_front(); n_compared++;
        if (ans_dm !== e) begin n_mismatched++; $display("FAIL pass_write: ans_dm=%h expected=%h", ans_dm, e); end
        step(1'b1, 1'b1, 1'b0, 1'b1, a_tab[3], 8'h00, e_tab[3]);
        e = exp_q.pop_front(); n_compared++;
        if (ans_dm !== e) begin n_mismatched++; $display("FAIL pass_write_readback: ans_dm=%h expected=%h", ans_dm, e); end
    endtask

    task automatic test_load_cleared();
        logic [7:0] e;
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 8'h00, 8'h00);
        e = exp_q.pop_front(); n_compared++;
        if (ans_dm !== e) begin n_mismatched++; $display("FAIL load_cleared: ans_dm=%h expected=%h", ans_dm, e); end
    endtask

    task automatic test_store_load();
        logic [7:0] e;
        // Write edge returns old data; a second write cycle reads the new word.
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 8'hFF, 8'h00);
        e = exp_q.pop_front(); n_compared++;
        if (ans_dm !== e) begin n_mismatched++; $display("FAIL store_old: ans_dm=%h expected=%h", ans_dm, e); end
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 8'hFF, 8'hFF);
        e = exp_q.pop_front(); n_compared++;
        if (ans_dm !== e) begin n_mismatched++; $display("FAIL store_new: ans_dm=%h expected=%h", ans_dm, e); end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 8'h00, 8'hFF);
            e = exp_q.pop_front(); n_compared++;
            if (ans_dm !== e) begin n_mismatched++; $display("FAIL load[%0d]: ans_dm=%h expected=%h", i, ans_dm, e); end
        end
    endtask

    task automatic test_disabled();
        logic [7:0] e;
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'h04, 8'hAA, 8'h00);
        e = exp_q.pop_front(); n_compared++;
        if (ans_dm !== e) begin n_mismatched++; $display("FAIL disabled_rd: ans_dm=%h expected=%h", ans_dm, e); end
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h04, 8'h00, 8'h00);
        e = exp_q.pop_front(); n_compared++;
        if (ans_dm !== e) begin n_mismatched++; $display("FAIL disabled_nowrite: ans_dm=%h expected=%h", ans_dm, e); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] e;
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 8'h77, 8'h00);
        e = exp_q.pop_front(); n_compared++;
        if (ans_dm !== e) begin n_mismatched++; $display("FAIL reset_mid: ans_dm=%h expected=%h", ans_dm, e); end
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 8'h00, 8'h00);
        e = exp_q.pop_front(); n_compared++;
        if (ans_dm !== e) begin n_mismatched++; $display("FAIL reset_mid_cleared: ans_dm=%h expected=%h", ans_dm, e); end
    endtask

    task automatic test_address_range();
        logic [7:0] e;
        logic [7:0] a_tab [4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        logic [7:0] d_tab [4] = '{8'hC3, 8'h5E, 8'h00, 8'h00};
        logic [7:0] e_tab [4] = '{8'h00, 8'h00, 8'hC3, 8'h5E};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, (i < 2), 1'b1, a_tab[i], d_tab[i], e_tab[i]);
            e = exp_q.pop_front(); n_compared++;
            if (ans_dm !== e) begin n_mismatched++; $display("FAIL addr_edge[%0d]: ans_dm=%h expected=%h", i, ans_dm, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        logic       rst, en, rw, sel;
        logic [7:0] a, d, pred;
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 59) != 0);
            en  = $urandom_range(0, 3) != 0;
            rw  = $urandom_range(0, 1);
            sel = $urandom_range(0, 3) != 0;
            a   = 8'($urandom_range(0, 7)) | (($urandom_range(0, 1) == 1) ? 8'hF8 : 8'h00);
            d   = 8'($urandom_range(0, 255));
            if (!rst)      pred = 8'h00;
            else if (!sel) pred = a;
            else if (!en)  pred = 8'h00;
            else           pred = model_mem[a];
            step(rst, en, rw, sel, a, d, pred);
            e = exp_q.pop_front(); n_compared++;
            if (ans_dm !== e) begin
                n_mismatched++;
                $display("FAIL random[%0d]: ans_dm=%h expected=%h (rst=%b en=%b rw=%b sel=%b a=%h d=%h)",
                         i, ans_dm, e, rst, en, rw, sel, a, d);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_compared     = 0;
        n_mismatched   = 0;
        reset          = 1'b0;
        ans_ex         = 8'h03;
        DM_data        = 8'hFF;
        mem_rw_ex      = 1'b0;
        mem_en_ex      = 1'b0;
        mem_mux_sel_dm = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

        test_reset();
        test_pass_through();
        test_load_cleared();
        test_store_load();
        test_disabled();
        test_reset_mid();
        test_address_range();
        test_back_to_back();

        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL leftover_expected: pending=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_data_memory_block

// File: doc/data_memory_block.md
Name: data_memory_block

Overview:
- Memory-access (DM) stage of the 8-bit pipelined processor.
- Holds a synchronous data memory addressed by the EX-stage ALU result (ans_ex), with DM_data as store data.
- Registers the stage result: either the loaded memory word or the pass-through ALU result, selected by mem_mux_sel_dm.
- ans_dm feeds the write-back stage.

Parameters:
- DATA_W, 8, data word width and width of ans_ex / DM_data / ans_dm
- ADDR_W, 8, address width; memory depth = 2**ADDR_W words (256)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset)
- ans_ex  input  DATA_W  ALU result from EX stage; memory address (low ADDR_W bits) and pass-through result
- DM_data  input  DATA_W  store data written to memory
- mem_rw_ex  input  1  1 = write (store), 0 = read (load)
- mem_en_ex  input  1  memory access enable
- mem_mux_sel_dm  input  1  1 = result is memory read data, 0 = result is ans_ex
- ans_dm  output  DATA_W  registered stage result

Behaviour:
- One clock, one synchronous active-low reset. Everything updates on the rising edge of clk only.
- Reset (reset==0 at a rising edge):
  - ans_dm <= 0.
  - All memory words <= 0.
  - Reset takes priority over any write in the same cycle.
- Memory write (reset==1, mem_en_ex==1, mem_rw_ex==1): mem[ans_ex[ADDR_W-1:0]] <= DM_data at the rising edge.
- Memory read data (combinational, internal):
  - rd = mem[ans_ex[ADDR_W-1:0]] when mem_en_ex==1.
  - rd = 0 when mem_en_ex==0.
- Read-during-write to the same address returns the old contents; the new value is visible from the next cycle.
- Result register (reset==1): ans_dm <= mem_mux_sel_dm ? rd : ans_ex. Latency is 1 cycle from inputs to ans_dm.
- mem_en_ex==0: no write occurs, whatever mem_rw_ex is.
- mem_mux_sel_dm==0: ans_dm passes ans_ex regardless of memory activity. A write still occurs if enabled.
- Address wrap: only the low ADDR_W bits of ans_ex address memory. With the default parameters the full 8-bit value is used (0x00..0xFF).
- Inputs change only between edges. No handshake; each cycle is independent.

Decomposition:
- Shared package: DATA_W and ADDR_W constants, plus a typedef for the data word.
- One natural sub-module, dm_ram: 2**ADDR_W x DATA_W single-port RAM with synchronous write, synchronous clear on reset, and combinational read gated by enable.
- The top module holds the output mux and the ans_dm register.

Test Plan:
- Reset: reset=0 for 2 edges with ans_ex=0x03, DM_data=0xFF, en=0, sel=0 -> ans_dm=0x00.
- Pass-through: reset=1, en=0, sel=0, ans_ex=0x03 -> ans_dm=0x03 one edge later. Change ans_ex to 0x5A -> ans_dm=0x5A next edge.
- Load from cleared memory: reset=1, en=1, rw=0, sel=1, ans_ex=0x03 -> ans_dm=0x00.
- Store then load:
  - en=1, rw=1, sel=1, ans_ex=0x03, DM_data=0xFF -> ans_dm=0x00 on the write edge (old data).
  - Continued rw=1 -> ans_dm=0xFF.
  - Switching to rw=0 -> ans_dm=0xFF on every following edge.
- Disabled access: en=0, rw=1, sel=1, ans_ex=0x04, DM_data=0xAA -> ans_dm=0x00 and no write; a later read of 0x04 returns 0x00.
- Reset mid-operation: after 0xFF is stored at 0x03, assert reset=0 for 1 edge alongside en=1, rw=1, ans_ex=0x03, DM_data=0x77 (reset must win) -> ans_dm=0x00; a later read of 0x03 returns 0x00.
